// File: rtl/sprite_shooter.sv
// Movable player sprite with a single-shot bullet; emits registered per-pixel hit flags.
// Optional 2x sprite scaling is enabled by defining SPRITE_SCALE2_EN.
module sprite_shooter #(
  parameter int SPR_W       = 11,
  parameter int SPR_H       = 8,
  parameter logic [SPR_W*SPR_H-1:0] SHAPE = {
    11'h020, 11'h7FF, 11'h3FE, 11'h070,
    11'h070, 11'h070, 11'h1FC, 11'h0F8
  },
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int START_X     = 315,
  parameter int START_Y     = 460,
  parameter int STEP        = 4,
  parameter int BULLET_STEP = 8,
  parameter int BULLET_LEN  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       vsync,
  input  logic       left,
  input  logic       right,
  input  logic       fire,
  output logic       sprite_px,
  output logic       bullet_px,
  output logic [9:0] pos_x,
  output logic       bullet_active
);

`ifdef SPRITE_SCALE2_EN
  localparam int SCALE_SH = 1;
`else
  localparam int SCALE_SH = 0;
`endif

  localparam int FOOT_W     = SPR_W << SCALE_SH;
  localparam int FOOT_H     = SPR_H << SCALE_SH;
  localparam int LAUNCH_OFF = FOOT_W / 2;
  localparam int MAX_X      = SCREEN_W - FOOT_W;
  localparam int IDX_W      = $clog2(SPR_W * SPR_H);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    FLYING = 1'b1
  } bstate_e;

  logic       vsync_q, vsync_d;
  logic       tick_s;
  logic       lft_l_q, lft_l_d;
  logic       rgt_l_q, rgt_l_d;
  logic       fir_l_q, fir_l_d;
  logic       lft_eff_s, rgt_eff_s, fir_eff_s;
  logic [9:0] pos_x_q, pos_x_d;
  bstate_e    state_q, state_d;
  logic [9:0] bul_x_q, bul_x_d;
  logic [9:0] bul_y_q, bul_y_d;
  logic       sprite_px_q, sprite_px_d;
  logic       bullet_px_q, bullet_px_d;

  logic [10:0] pos_ext_s, dec_s, inc_s;
  logic [10:0] x_ext_s, y_ext_s;
  logic        on_screen_s, spr_in_x_s, spr_in_y_s, bul_in_y_s;
  logic [9:0]  dx_s, dy_s, col_s, row_s;
  logic [IDX_W-1:0] shape_idx_s;

  // Frame tick and button latches; a press on the tick cycle is folded into that tick.
  always_comb begin
    vsync_d   = vsync;
    tick_s    = vsync_q & ~vsync;
    lft_eff_s = lft_l_q | left;
    rgt_eff_s = rgt_l_q | right;
    fir_eff_s = fir_l_q | fire;
    if (tick_s) begin
      lft_l_d = 1'b0;
      rgt_l_d = 1'b0;
      fir_l_d = 1'b0;
    end else begin
      lft_l_d = lft_eff_s;
      rgt_l_d = rgt_eff_s;
      fir_l_d = fir_eff_s;
    end
  end

  // Horizontal movement, evaluated at 11 bits so under/overflow shows before clamping.
  always_comb begin
    pos_x_d   = pos_x_q;
    pos_ext_s = {1'b0, pos_x_q};
    dec_s     = pos_ext_s - 11'(STEP);
    inc_s     = pos_ext_s + 11'(STEP);
    if (tick_s && lft_eff_s && !rgt_eff_s) begin
      if (dec_s[10]) begin
        pos_x_d = 10'd0;
      end else begin
        pos_x_d = dec_s[9:0];
      end
    end else if (tick_s && rgt_eff_s && !lft_eff_s) begin
      if (inc_s > 11'(MAX_X)) begin
        pos_x_d = 10'(MAX_X);
      end else begin
        pos_x_d = inc_s[9:0];
      end
    end else begin
      pos_x_d = pos_x_q;
    end
  end

  // Bullet state machine; launch column uses the sprite position before this tick's move.
  always_comb begin
    state_d = state_q;
    bul_x_d = bul_x_q;
    bul_y_d = bul_y_q;
    case (state_q)
      IDLE: begin
        if (tick_s && fir_eff_s) begin
          state_d = FLYING;
          bul_x_d = pos_x_q + 10'(LAUNCH_OFF);
          bul_y_d = 10'(START_Y - BULLET_LEN);
        end else begin
          state_d = IDLE;
        end
      end
      FLYING: begin
        if (tick_s) begin
          if (bul_y_q < 10'(BULLET_STEP)) begin
            state_d = IDLE;
          end else begin
            bul_y_d = bul_y_q - 10'(BULLET_STEP);
          end
        end else begin
          state_d = FLYING;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Pixel hit tests for the current (x,y), registered one cycle later.
  always_comb begin
    x_ext_s     = {1'b0, x};
    y_ext_s     = {1'b0, y};
    on_screen_s = (x < 10'(SCREEN_W)) && (y < 10'(SCREEN_H));
    spr_in_x_s  = (x_ext_s >= pos_ext_s) && (x_ext_s < pos_ext_s + 11'(FOOT_W));
    spr_in_y_s  = (y_ext_s >= 11'(START_Y)) && (y_ext_s < 11'(START_Y + FOOT_H));
    dx_s        = x - pos_x_q;
    dy_s        = y - 10'(START_Y);
    col_s       = dx_s >> SCALE_SH;
    row_s       = dy_s >> SCALE_SH;
    shape_idx_s = IDX_W'(row_s) * IDX_W'(SPR_W) + IDX_W'(col_s);
    bul_in_y_s  = (y_ext_s >= {1'b0, bul_y_q}) &&
                  (y_ext_s < {1'b0, bul_y_q} + 11'(BULLET_LEN));
    if (on_screen_s && spr_in_x_s && spr_in_y_s) begin
      sprite_px_d = SHAPE[shape_idx_s];
    end else begin
      sprite_px_d = 1'b0;
    end
    if (on_screen_s && (state_q == FLYING) && (x == bul_x_q) && bul_in_y_s) begin
      bullet_px_d = 1'b1;
    end else begin
      bullet_px_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      vsync_q     <= 1'b1;
      lft_l_q     <= 1'b0;
      rgt_l_q     <= 1'b0;
      fir_l_q     <= 1'b0;
      pos_x_q     <= 10'(START_X);
      state_q     <= IDLE;
      bul_x_q     <= 10'd0;
      bul_y_q     <= 10'd0;
      sprite_px_q <= 1'b0;
      bullet_px_q <= 1'b0;
    end else begin
      vsync_q     <= vsync_d;
      lft_l_q     <= lft_l_d;
      rgt_l_q     <= rgt_l_d;
      fir_l_q     <= fir_l_d;
      pos_x_q     <= pos_x_d;
      state_q     <= state_d;
      bul_x_q     <= bul_x_d;
      bul_y_q     <= bul_y_d;
      sprite_px_q <= sprite_px_d;
      bullet_px_q <= bullet_px_d;
    end
  end

  assign sprite_px     = sprite_px_q;
  assign bullet_px     = bullet_px_q;
  assign pos_x         = pos_x_q;
  assign bullet_active = (state_q == FLYING);

endmodule

// File: tb/tb_sprite_shooter.sv
// Directed, table-driven bench for sprite_shooter (default 1x build).
module tb_sprite_shooter;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] x, y;
  logic       vsync, left, right, fire;
  logic       sprite_px, bullet_px, bullet_active;
  logic [9:0] pos_x;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [9:0] px;
    logic [9:0] py;
    logic       exp_spr;
    logic       exp_bul;
  } vec_t;

  vec_t tab1[14];
  vec_t tab2[7];

  sprite_shooter dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .vsync(vsync),
    .left(left), .right(right), .fire(fire),
    .sprite_px(sprite_px), .bullet_px(bullet_px),
    .pos_x(pos_x), .bullet_active(bullet_active)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic frame();
    vsync = 1'b0;
    step();
    vsync = 1'b1;
    step();
  endtask

  task automatic pix(input logic [9:0] px, input logic [9:0] py,
                     input logic es, input logic eb, input string nm);
    x = px;
    y = py;
    step();
    chk({nm, " sprite_px"}, {31'd0, sprite_px}, {31'd0, es});
    chk({nm, " bullet_px"}, {31'd0, bullet_px}, {31'd0, eb});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    // Sprite at pos_x=315, rows top..bottom: cols 3-7, 2-8, 4-6 x3, 1-9, 0-10, 5
    tab1[0]  = '{10'd318, 10'd460, 1'b1, 1'b0};
    tab1[1]  = '{10'd315, 10'd460, 1'b0, 1'b0};
    tab1[2]  = '{10'd320, 10'd467, 1'b1, 1'b0};
    tab1[3]  = '{10'd320, 10'd468, 1'b0, 1'b0};
    tab1[4]  = '{10'd325, 10'd466, 1'b1, 1'b0};
    tab1[5]  = '{10'd326, 10'd466, 1'b0, 1'b0};
    tab1[6]  = '{10'd314, 10'd466, 1'b0, 1'b0};
    tab1[7]  = '{10'd316, 10'd465, 1'b1, 1'b0};
    tab1[8]  = '{10'd315, 10'd465, 1'b0, 1'b0};
    tab1[9]  = '{10'd319, 10'd462, 1'b1, 1'b0};
    tab1[10] = '{10'd318, 10'd462, 1'b0, 1'b0};
    tab1[11] = '{10'd700, 10'd460, 1'b0, 1'b0};
    tab1[12] = '{10'd318, 10'd459, 1'b0, 1'b0};
    tab1[13] = '{10'd321, 10'd461, 1'b1, 1'b0};
    // Bullet at x=320, y=456..459; sprite moved to pos_x=319
    tab2[0]  = '{10'd320, 10'd456, 1'b0, 1'b1};
    tab2[1]  = '{10'd320, 10'd459, 1'b0, 1'b1};
    tab2[2]  = '{10'd320, 10'd455, 1'b0, 1'b0};
    tab2[3]  = '{10'd320, 10'd460, 1'b0, 1'b0};
    tab2[4]  = '{10'd322, 10'd460, 1'b1, 1'b0};
    tab2[5]  = '{10'd321, 10'd457, 1'b0, 1'b0};
    tab2[6]  = '{10'd319, 10'd457, 1'b0, 1'b0};

    reset = 1'b1; vsync = 1'b1; x = 10'd0; y = 10'd0;
    left = 1'b0; right = 1'b0; fire = 1'b0;
    step();
    step();
    chk("reset pos_x", {22'd0, pos_x}, 32'd315);
    chk("reset sprite_px", {31'd0, sprite_px}, 32'd0);
    chk("reset bullet_px", {31'd0, bullet_px}, 32'd0);
    chk("reset bullet_active", {31'd0, bullet_active}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) begin
      pix(tab1[i].px, tab1[i].py, tab1[i].exp_spr, tab1[i].exp_bul, $sformatf("tab1[%0d]", i));
    end

    // One-cycle right press mid-frame, consumed by the next tick only
    right = 1'b1; step(); right = 1'b0; step();
    frame();
    chk("right pulse pos_x", {22'd0, pos_x}, 32'd319);
    frame();
    chk("idle frame pos_x", {22'd0, pos_x}, 32'd319);

    // Right held: saturates at 629
    right = 1'b1;
    for (int f = 1; f <= 100; f++) begin
      frame();
      if (f == 77) chk("right f77 pos_x", {22'd0, pos_x}, 32'd627);
      if (f == 78) chk("right f78 pos_x", {22'd0, pos_x}, 32'd629);
    end
    chk("right f100 pos_x", {22'd0, pos_x}, 32'd629);
    right = 1'b0;
    do_reset();

    // Left held: clamps at 0 without wrapping
    left = 1'b1;
    for (int f = 1; f <= 200; f++) begin
      frame();
      if (f == 78) chk("left f78 pos_x", {22'd0, pos_x}, 32'd3);
      if (f == 79) chk("left f79 pos_x", {22'd0, pos_x}, 32'd0);
    end
    chk("left f200 pos_x", {22'd0, pos_x}, 32'd0);
    left = 1'b0;
    do_reset();

    // Fire with right in the same frame: launch from pre-move pos_x
    fire = 1'b1; right = 1'b1; step(); fire = 1'b0; right = 1'b0;
    frame();
    chk("launch bullet_active", {31'd0, bullet_active}, 32'd1);
    chk("launch pos_x", {22'd0, pos_x}, 32'd319);
    for (int i = 0; i < 7; i++) begin
      pix(tab2[i].px, tab2[i].py, tab2[i].exp_spr, tab2[i].exp_bul, $sformatf("tab2[%0d]", i));
    end

    // Left+right+fire together while flying: no move, no relaunch
    left = 1'b1; right = 1'b1; fire = 1'b1; step();
    left = 1'b0; right = 1'b0; fire = 1'b0;
    frame();
    chk("both buttons pos_x", {22'd0, pos_x}, 32'd319);
    chk("refire bullet_active", {31'd0, bullet_active}, 32'd1);
    pix(10'd320, 10'd448, 1'b0, 1'b1, "bul y448");
    pix(10'd320, 10'd456, 1'b0, 1'b0, "bul old y456");
    pix(10'd320, 10'd447, 1'b0, 1'b0, "bul y447");

    for (int f = 0; f < 56; f++) frame();
    chk("bul_y0 bullet_active", {31'd0, bullet_active}, 32'd1);
    pix(10'd320, 10'd0, 1'b0, 1'b1, "bul y0");
    pix(10'd320, 10'd3, 1'b0, 1'b1, "bul y3");
    pix(10'd320, 10'd4, 1'b0, 1'b0, "bul y4");
    frame();
    chk("land bullet_active", {31'd0, bullet_active}, 32'd0);
    pix(10'd320, 10'd0, 1'b0, 1'b0, "landed y0");

    // Reset mid-flight at bul_y=200
    do_reset();
    fire = 1'b1; step(); fire = 1'b0;
    frame();
    right = 1'b1;
    for (int f = 0; f < 32; f++) frame();
    right = 1'b0;
    chk("midflight pos_x", {22'd0, pos_x}, 32'd443);
    pix(10'd320, 10'd200, 1'b0, 1'b1, "midflight y200");
    reset = 1'b1;
    step();
    chk("midreset bullet_active", {31'd0, bullet_active}, 32'd0);
    chk("midreset pos_x", {22'd0, pos_x}, 32'd315);
    chk("midreset bullet_px", {31'd0, bullet_px}, 32'd0);
    chk("midreset sprite_px", {31'd0, sprite_px}, 32'd0);
    reset = 1'b0;
    pix(10'd318, 10'd460, 1'b1, 1'b0, "post reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
